// File: rtl/wb_arbiter.sv
// Writeback arbiter: shares the scalar, FP and vector writeback ports among
// NUM_REQ functional units. Each register class has its own round-robin
// pointer and a single registered output stage. Class 11 requests are
// accepted and dropped, and they set a sticky illegal flag.
module wb_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned FLEN    = 32,
    parameter int unsigned VLEN    = 128
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_REQ-1:0]      req_valid,
    output logic [NUM_REQ-1:0]      req_ready,
    input  logic [2*NUM_REQ-1:0]    req_class,
    input  logic [5*NUM_REQ-1:0]    req_rd,
    input  logic [VLEN*NUM_REQ-1:0] req_data,
    input  logic                    flush_all,
    output logic                    wb_scalar_valid,
    output logic [4:0]              wb_scalar_rd,
    output logic [XLEN-1:0]         wb_scalar_data,
    output logic                    wb_fp_valid,
    output logic [4:0]              wb_fp_rd,
    output logic [FLEN-1:0]         wb_fp_data,
    output logic                    wb_vec_valid,
    output logic [4:0]              wb_vec_rd,
    output logic [VLEN-1:0]         wb_vec_data,
    output logic                    illegal_class
);

    localparam int unsigned PW   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned NCLS = 3;  // 0 scalar, 1 FP, 2 vector

    typedef logic [PW-1:0] ptr_t;

    ptr_t               rr_ptr_q [NCLS];
    logic [NCLS-1:0]    cls_grant;
    ptr_t               win_idx [NCLS];
    logic [4:0]         win_rd [NCLS];
    logic [NUM_REQ-1:0] grant_vec;
    logic [NUM_REQ-1:0] illegal_req;

    logic               scalar_valid_q;
    logic [4:0]         scalar_rd_q;
    logic [XLEN-1:0]    scalar_data_q;
    logic               fp_valid_q;
    logic [4:0]         fp_rd_q;
    logic [FLEN-1:0]    fp_data_q;
    logic               vec_valid_q;
    logic [4:0]         vec_rd_q;
    logic [VLEN-1:0]    vec_data_q;
    logic               illegal_q;

    // (base + off) mod NUM_REQ, with off <= NUM_REQ
    function automatic ptr_t wrap_add(input ptr_t base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ptr_t'(sum);
    endfunction

    // True when requester idx is valid and carries class cls
    function automatic logic req_hit(input ptr_t idx, input int unsigned cls);
        return req_valid[idx] && (req_class[2*32'(idx) +: 2] == 2'(cls));
    endfunction

    // Per-class round-robin search starting at the class pointer; flush blocks all grants
    always_comb begin
        grant_vec   = '0;
        illegal_req = '0;
        for (int unsigned c = 0; c < NCLS; c++) begin
            cls_grant[c] = 1'b0;
            win_idx[c]   = '0;
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                if (!cls_grant[c] && !flush_all && req_hit(wrap_add(rr_ptr_q[c], k), c)) begin
                    cls_grant[c] = 1'b1;
                    win_idx[c]   = wrap_add(rr_ptr_q[c], k);
                end
            end
            win_rd[c] = req_rd[5*32'(win_idx[c]) +: 5];
            if (cls_grant[c]) grant_vec[win_idx[c]] = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            illegal_req[i] = !flush_all && req_valid[i] && (req_class[2*i +: 2] == 2'b11);
        end
        req_ready = grant_vec | illegal_req;
    end

    // Register winners per class, advance pointers, track sticky illegal flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCLS; c++) rr_ptr_q[c] <= '0;
            scalar_valid_q <= 1'b0;
            scalar_rd_q    <= '0;
            scalar_data_q  <= '0;
            fp_valid_q     <= 1'b0;
            fp_rd_q        <= '0;
            fp_data_q      <= '0;
            vec_valid_q    <= 1'b0;
            vec_rd_q       <= '0;
            vec_data_q     <= '0;
            illegal_q      <= 1'b0;
        end else if (flush_all) begin
            for (int c = 0; c < NCLS; c++) rr_ptr_q[c] <= '0;
            scalar_valid_q <= 1'b0;
            fp_valid_q     <= 1'b0;
            vec_valid_q    <= 1'b0;
        end else begin
            for (int c = 0; c < NCLS; c++) begin
                if (cls_grant[c]) rr_ptr_q[c] <= wrap_add(win_idx[c], 1);
            end
            // x0 writes are consumed but never strobed
            scalar_valid_q <= cls_grant[0] && (win_rd[0] != 5'd0);
            if (cls_grant[0]) begin
                scalar_rd_q   <= win_rd[0];
                scalar_data_q <= req_data[VLEN*32'(win_idx[0]) +: XLEN];
            end
            fp_valid_q <= cls_grant[1];
            if (cls_grant[1]) begin
                fp_rd_q   <= win_rd[1];
                fp_data_q <= req_data[VLEN*32'(win_idx[1]) +: FLEN];
            end
            vec_valid_q <= cls_grant[2];
            if (cls_grant[2]) begin
                vec_rd_q   <= win_rd[2];
                vec_data_q <= req_data[VLEN*32'(win_idx[2]) +: VLEN];
            end
            if (|illegal_req) illegal_q <= 1'b1;
        end
    end

    // Flush masks the strobes in the same cycle the scoreboard is flushed
    assign wb_scalar_valid = scalar_valid_q & ~flush_all;
    assign wb_scalar_rd    = scalar_rd_q;
    assign wb_scalar_data  = scalar_data_q;
    assign wb_fp_valid     = fp_valid_q & ~flush_all;
    assign wb_fp_rd        = fp_rd_q;
    assign wb_fp_data      = fp_data_q;
    assign wb_vec_valid    = vec_valid_q & ~flush_all;
    assign wb_vec_rd       = vec_rd_q;
    assign wb_vec_data     = vec_data_q;
    assign illegal_class   = illegal_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Bench for wb_arbiter: directed scenarios with literal expectations plus a
// per-cycle reference model of the round-robin / latency-1 writeback rules.
module tb_wb_arbiter;

    localparam int N  = 4;
    localparam int XL = 32;
    localparam int FL = 32;
    localparam int VL = 128;

    logic            clk   = 1'b0;
    logic            rst_n = 1'b1;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [2*N-1:0]  req_class;
    logic [5*N-1:0]  req_rd;
    logic [VL*N-1:0] req_data;
    logic            flush_all;
    logic            wb_scalar_valid;
    logic [4:0]      wb_scalar_rd;
    logic [XL-1:0]   wb_scalar_data;
    logic            wb_fp_valid;
    logic [4:0]      wb_fp_rd;
    logic [FL-1:0]   wb_fp_data;
    logic            wb_vec_valid;
    logic [4:0]      wb_vec_rd;
    logic [VL-1:0]   wb_vec_data;
    logic            illegal_class;

    // Per-requester stimulus fields
    logic [N-1:0]    v;
    logic [1:0]      cls [N];
    logic [4:0]      rd  [N];
    logic [VL-1:0]   dat [N];
    logic            flush;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_valid = v;
        flush_all = flush;
        req_class = '0;
        req_rd    = '0;
        req_data  = '0;
        for (int i = 0; i < N; i++) begin
            req_class[2*i +: 2]   = cls[i];
            req_rd[5*i +: 5]      = rd[i];
            req_data[VL*i +: VL]  = dat[i];
        end
    end

    wb_arbiter #(.NUM_REQ(N), .XLEN(XL), .FLEN(FL), .VLEN(VL)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_class       (req_class),
        .req_rd          (req_rd),
        .req_data        (req_data),
        .flush_all       (flush_all),
        .wb_scalar_valid (wb_scalar_valid),
        .wb_scalar_rd    (wb_scalar_rd),
        .wb_scalar_data  (wb_scalar_data),
        .wb_fp_valid     (wb_fp_valid),
        .wb_fp_rd        (wb_fp_rd),
        .wb_fp_data      (wb_fp_data),
        .wb_vec_valid    (wb_vec_valid),
        .wb_vec_rd       (wb_vec_rd),
        .wb_vec_data     (wb_vec_data),
        .illegal_class   (illegal_class)
    );

    task automatic chk(input string name, input logic [VL-1:0] act, input logic [VL-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: pointers, expected registered writebacks, sticky flag
    int            m_ptr [3];
    logic          m_v   [3];
    logic [4:0]    m_rd  [3];
    logic [VL-1:0] m_dat [3];
    logic          m_ill;

    always @(negedge clk) begin
        int           w [3];
        logic [N-1:0] er;
        if (!rst_n) begin
            for (int c = 0; c < 3; c++) begin
                m_ptr[c] = 0; m_v[c] = 1'b0; m_rd[c] = '0; m_dat[c] = '0;
            end
            m_ill = 1'b0;
            chk("rst_scalar_valid", wb_scalar_valid, 0);
            chk("rst_fp_valid", wb_fp_valid, 0);
            chk("rst_vec_valid", wb_vec_valid, 0);
            chk("rst_rd", {wb_scalar_rd, wb_fp_rd, wb_vec_rd}, 0);
            chk("rst_data", wb_vec_data | wb_scalar_data | wb_fp_data, 0);
            chk("rst_illegal", illegal_class, 0);
        end else begin
            er = '0;
            for (int c = 0; c < 3; c++) begin
                w[c] = -1;
                if (!flush) begin
                    for (int k = 0; k < N; k++) begin
                        int i;
                        i = (m_ptr[c] + k) % N;
                        if (w[c] < 0 && v[i] && cls[i] == 2'(c)) w[c] = i;
                    end
                end
                if (w[c] >= 0) er[w[c]] = 1'b1;
            end
            for (int i = 0; i < N; i++) begin
                if (!flush && v[i] && cls[i] == 2'b11) er[i] = 1'b1;
            end
            chk("m_ready", req_ready, er);
            chk("m_scalar_valid", wb_scalar_valid, m_v[0] && !flush);
            chk("m_fp_valid", wb_fp_valid, m_v[1] && !flush);
            chk("m_vec_valid", wb_vec_valid, m_v[2] && !flush);
            if (m_v[0] && !flush) begin
                chk("m_scalar_rd", wb_scalar_rd, m_rd[0]);
                chk("m_scalar_data", wb_scalar_data, m_dat[0][XL-1:0]);
            end
            if (m_v[1] && !flush) begin
                chk("m_fp_rd", wb_fp_rd, m_rd[1]);
                chk("m_fp_data", wb_fp_data, m_dat[1][FL-1:0]);
            end
            if (m_v[2] && !flush) begin
                chk("m_vec_rd", wb_vec_rd, m_rd[2]);
                chk("m_vec_data", wb_vec_data, m_dat[2]);
            end
            chk("m_illegal", illegal_class, m_ill);
            // State after the coming clock edge (inputs stay put until then)
            if (flush) begin
                for (int c = 0; c < 3; c++) begin
                    m_ptr[c] = 0; m_v[c] = 1'b0;
                end
            end else begin
                for (int c = 0; c < 3; c++) begin
                    if (w[c] >= 0) begin
                        m_ptr[c] = (w[c] + 1) % N;
                        m_v[c]   = (c != 0) || (rd[w[c]] != 5'd0);
                        m_rd[c]  = rd[w[c]];
                        m_dat[c] = dat[w[c]];
                    end else begin
                        m_v[c] = 1'b0;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (v[i] && cls[i] == 2'b11) m_ill = 1'b1;
                end
            end
        end
    end

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        v = '0;
        flush = 1'b0;
        for (int i = 0; i < N; i++) begin
            cls[i] = 2'b00; rd[i] = '0; dat[i] = '0;
        end
    endtask

    task automatic set_req(input int i, input logic [1:0] c, input logic [4:0] r,
                           input logic [VL-1:0] d);
        v[i] = 1'b1; cls[i] = c; rd[i] = r; dat[i] = d;
    endtask

    task automatic do_reset();
        next_cyc();
        clr();
        rst_n = 1'b0;
        next_cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        clr();
        #2 rst_n = 1'b0;
        next_cyc();
        next_cyc();
        rst_n = 1'b1;

        // 1: single scalar writeback, latency 1
        set_req(0, 2'b00, 5'd5, 'h1234);
        @(negedge clk); chk("t1_ready", req_ready, 4'b0001);
        next_cyc(); clr();
        @(negedge clk);
        chk("t1_valid", wb_scalar_valid, 1);
        chk("t1_rd", wb_scalar_rd, 5);
        chk("t1_data", wb_scalar_data, 'h1234);
        next_cyc();
        @(negedge clk); chk("t1_valid_drop", wb_scalar_valid, 0);

        // 2: round-robin among held scalar requests
        do_reset();
        set_req(0, 2'b00, 5'd1, 'h11);
        set_req(1, 2'b00, 5'd2, 'h22);
        set_req(2, 2'b00, 5'd3, 'h33);
        @(negedge clk); chk("t2_ready_a", req_ready, 4'b0001);
        next_cyc(); v[0] = 1'b0;
        @(negedge clk); chk("t2_ready_b", req_ready, 4'b0010); chk("t2_rd_a", wb_scalar_rd, 1);
        next_cyc(); v[1] = 1'b0;
        @(negedge clk); chk("t2_ready_c", req_ready, 4'b0100); chk("t2_rd_b", wb_scalar_rd, 2);
        next_cyc(); v[2] = 1'b0;
        set_req(0, 2'b00, 5'd8, 'h88);
        set_req(3, 2'b00, 5'd9, 'h99);
        @(negedge clk); chk("t2_ready_d", req_ready, 4'b1000); chk("t2_rd_c", wb_scalar_rd, 3);
        next_cyc(); v[3] = 1'b0;
        @(negedge clk); chk("t2_ready_e", req_ready, 4'b0001); chk("t2_rd_d", wb_scalar_rd, 9);
        next_cyc(); v[0] = 1'b0;
        @(negedge clk); chk("t2_rd_e", wb_scalar_rd, 8);
        next_cyc();

        // 3: one grant per class in the same cycle
        do_reset();
        set_req(0, 2'b00, 5'd4, 'hA4);
        set_req(1, 2'b01, 5'd6, 'hB6);
        set_req(2, 2'b10, 5'd7, {64'hDEAD_BEEF_0000_0001, 64'h7});
        @(negedge clk); chk("t3_ready", req_ready, 4'b0111);
        next_cyc(); clr();
        @(negedge clk);
        chk("t3_valids", {wb_scalar_valid, wb_fp_valid, wb_vec_valid}, 3'b111);
        chk("t3_rds", {wb_scalar_rd, wb_fp_rd, wb_vec_rd}, {5'd4, 5'd6, 5'd7});
        chk("t3_vec_data", wb_vec_data, {64'hDEAD_BEEF_0000_0001, 64'h7});
        next_cyc();

        // 4: scalar x0 is accepted but not strobed
        do_reset();
        set_req(1, 2'b00, 5'd0, 'h55);
        @(negedge clk); chk("t4_ready", req_ready, 4'b0010);
        next_cyc(); clr();
        @(negedge clk); chk("t4_valid", wb_scalar_valid, 0);
        next_cyc();

        // 5: flush squashes in-flight result and resets the pointer
        do_reset();
        set_req(2, 2'b00, 5'd10, 'hAA);
        @(negedge clk); chk("t5_ready_a", req_ready, 4'b0100);
        next_cyc(); clr();
        flush = 1'b1;
        set_req(0, 2'b00, 5'd12, 'hC0);
        set_req(3, 2'b00, 5'd13, 'hD3);
        @(negedge clk); chk("t5_ready_flush", req_ready, 4'b0000);
        chk("t5_valid_flush", wb_scalar_valid, 0);
        next_cyc(); flush = 1'b0;
        @(negedge clk); chk("t5_ready_b", req_ready, 4'b0001);
        chk("t5_valid_after", wb_scalar_valid, 0);
        next_cyc(); v[0] = 1'b0;
        @(negedge clk); chk("t5_ready_c", req_ready, 4'b1000); chk("t5_rd_a", wb_scalar_rd, 12);
        next_cyc(); v[3] = 1'b0;
        @(negedge clk); chk("t5_rd_b", wb_scalar_rd, 13);
        next_cyc();

        // 6: illegal class accepted, dropped, sticky until reset
        do_reset();
        set_req(3, 2'b11, 5'd1, 'h1);
        @(negedge clk); chk("t6_ready", req_ready, 4'b1000);
        next_cyc(); clr();
        @(negedge clk);
        chk("t6_no_strobe", {wb_scalar_valid, wb_fp_valid, wb_vec_valid}, 3'b000);
        chk("t6_illegal", illegal_class, 1);
        next_cyc(); next_cyc();
        @(negedge clk); chk("t6_sticky", illegal_class, 1);
        do_reset();
        @(negedge clk); chk("t6_cleared", illegal_class, 0);
        next_cyc();

        // Mixed traffic against the model, with occasional flushes
        do_reset();
        for (int n = 0; n < 300; n++) begin
            v = N'($urandom);
            for (int i = 0; i < N; i++) begin
                cls[i] = 2'($urandom);
                rd[i]  = 5'($urandom);
                dat[i] = {$urandom, $urandom, $urandom, $urandom};
            end
            flush = ($urandom_range(0, 9) == 0);
            @(negedge clk);
            next_cyc();
        end
        clr();
        next_cyc();
        next_cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
